// File: rtl/mem_if_pkg.sv
// Shared types and constants for the word-addressed memory responder.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    // Number of LFSR bits that form the extra stall cycles (0..3)
    localparam int          STALL_BITS = 2;

    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; shifts left, feedback enters bit 0, advances on en.
module lfsr16
    import mem_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_state;

    // Shift register, reloaded with the seed on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= seed;
        end else if (en) begin
            r_state <= {r_state[14:0], lfsr_feedback(r_state)};
        end
    end

    assign q = r_state;

endmodule

// File: rtl/dmem_responder.sv
// Variable-latency memory responder: fixed read/write latency plus optional
// LFSR-driven extra stall cycles, one-cycle ready pulse per access.
module dmem_responder
    import mem_if_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          DEPTH         = 1024,
    parameter int          READ_LATENCY  = 5,
    parameter int          WRITE_LATENCY = 5,
    parameter logic [15:0] STALL_SEED    = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       write,
    input  logic                       read,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       ready,
    output logic                       err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int NB      = DATA_WIDTH / 8;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // Largest count is MAX_LAT-1 plus 3 stall cycles
    localparam int CNT_W   = $clog2(MAX_LAT + 4);

    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    resp_state_e           r_state;
    resp_state_e           w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wr;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_from_in;
    logic                  w_enter_resp;
    logic                  w_commit;
    logic                  w_is_wr;
    logic [AW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NB-1:0]         w_strb;
    logic [CNT_W-1:0]      w_lat;
    logic [CNT_W-1:0]      w_cnt_init;
    logic [15:0]           w_lfsr;
    logic [STALL_BITS-1:0] w_extra;
    logic [15-STALL_BITS:0] w_unused_lfsr;

    assign w_req    = read | write;
    assign w_accept = (r_state == IDLE) && w_req;

    generate
        if (STALL_SEED != 16'h0000) begin : g_stall
            lfsr16 u_lfsr (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_accept),
                .seed  (STALL_SEED),
                .q     (w_lfsr)
            );
        end else begin : g_no_stall
            assign w_lfsr = '0;
        end
    endgenerate

    assign w_extra       = w_lfsr[STALL_BITS-1:0];
    assign w_unused_lfsr = w_lfsr[15:STALL_BITS];

    // A simultaneous read+write is served as a write
    assign w_lat      = write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
    assign w_cnt_init = w_lat + CNT_W'(w_extra);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = (w_cnt_init == '0) ? RESP : BUSY;
            BUSY:    if (r_cnt == CNT_W'(1)) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With a single-cycle latency the access commits straight from IDLE,
    // before the capture registers are loaded, so take operands from the ports
    assign w_from_in    = (r_state == IDLE);
    assign w_addr       = w_from_in ? addr  : r_addr;
    assign w_wdata      = w_from_in ? wdata : r_wdata;
    assign w_strb       = w_from_in ? wstrb : r_wstrb;
    assign w_is_wr      = w_from_in ? write : r_wr;
    assign w_enter_resp = (r_state != RESP) && (w_next == RESP);
    assign w_commit     = w_enter_resp && w_is_wr && rst_n;

    // State register, latency counter, op type and read-data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= w_cnt_init;
                r_wr  <= write;
                r_err <= read & write;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_enter_resp && !w_is_wr) begin
                r_rdata <= mem_array[w_addr];
            end
        end
    end

    // Request operands captured at acceptance; later port changes are ignored
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
        end
    end

    // Byte-masked write commit on the edge entering RESP; array is never cleared
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (w_strb[i]) begin
                    mem_array[w_addr][i*8 +: 8] <= w_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Outputs decoded from state
    always_comb begin
        ready = (r_state == RESP);
        err   = (r_state == RESP) && r_err;
        rdata = r_rdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: fixed-latency instance plus a
// stall-injecting instance checked against an independent LFSR model.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic [9:0]  d_addr, s_addr;
    logic [31:0] d_wdata, s_wdata;
    logic [3:0]  d_wstrb, s_wstrb;
    logic        d_write, s_write, d_read, s_read;
    logic [31:0] d_rdata, s_rdata;
    logic        d_ready, s_ready, d_err, s_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(
        .DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(5), .WRITE_LATENCY(5),
        .STALL_SEED(16'h0000)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .addr(d_addr), .wdata(d_wdata), .wstrb(d_wstrb),
        .write(d_write), .read(d_read), .rdata(d_rdata), .ready(d_ready), .err(d_err)
    );

    dmem_responder #(
        .DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(5), .WRITE_LATENCY(5),
        .STALL_SEED(16'hACE1)
    ) u_stall (
        .clk(clk), .rst_n(rst_n), .addr(s_addr), .wdata(s_wdata), .wstrb(s_wstrb),
        .write(s_write), .read(s_read), .rdata(s_rdata), .ready(s_ready), .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Tick until the selected instance pulses ready (bounded)
    task automatic wait_rdy(input bit sel, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(sel ? s_ready : d_ready) && n < 64);
    endtask

    // One complete access: drive, wait for ready, drop request, one idle cycle
    task automatic do_acc(input bit sel, input bit rd, input bit wr, input logic [9:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          output int lat, output logic [31:0] rd_o, output logic err_o);
        if (sel) begin
            s_read = rd; s_write = wr; s_addr = a; s_wdata = wd; s_wstrb = st;
        end else begin
            d_read = rd; d_write = wr; d_addr = a; d_wdata = wd; d_wstrb = st;
        end
        wait_rdy(sel, lat);
        rd_o  = sel ? s_rdata : d_rdata;
        err_o = sel ? s_err : d_err;
        if (sel) begin
            s_read = 1'b0; s_write = 1'b0;
        end else begin
            d_read = 1'b0; d_write = 1'b0;
        end
        tick();
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          seen;
        logic [31:0] rdv;
        logic        errv;
        logic [15:0] lfsr_m;
        int          extra;

        rst_n = 1'b0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        s_read = 0; s_write = 0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ready", 32'(d_ready), 32'd0);
        check("rst_err",   32'(d_err),   32'd0);
        check("rst_rdata", d_rdata,      32'd0);
        check("rst_ready_stall", 32'(s_ready), 32'd0);
        check("rst_rdata_stall", s_rdata,      32'd0);
        rst_n = 1'b1;
        tick();

        // Preload through the write port
        do_acc(0, 0, 1, 10'd3, 32'h1234_5678, 4'hF, lat, rdv, errv);
        check("preload_wr_lat", 32'(lat), 32'd5);
        check("preload_wr_err", 32'(errv), 32'd0);
        do_acc(0, 0, 1, 10'd7, 32'h0000_0000, 4'hF, lat, rdv, errv);
        do_acc(0, 0, 1, 10'd9, 32'h1357_9BDF, 4'hF, lat, rdv, errv);
        do_acc(0, 0, 1, 10'd2, 32'h0000_0000, 4'hF, lat, rdv, errv);
        check("rdata_untouched_by_writes", d_rdata, 32'd0);

        // Read word 3: ready only in T+5
        d_read = 1'b1; d_addr = 10'd3;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("rd3_ready_c%0d", k), 32'(d_ready), (k == 5) ? 32'd1 : 32'd0);
        end
        check("rd3_rdata", d_rdata, 32'h1234_5678);
        check("rd3_err",   32'(d_err), 32'd0);
        d_read = 1'b0;
        tick();
        check("rd3_ready_drop", 32'(d_ready), 32'd0);

        // Byte-strobed write, then read back
        do_acc(0, 0, 1, 10'd7, 32'hDEAD_BEEF, 4'b0101, lat, rdv, errv);
        check("wr7_lat", 32'(lat), 32'd5);
        check("rdata_held_over_write", d_rdata, 32'h1234_5678);
        do_acc(0, 1, 0, 10'd7, 32'h0, 4'h0, lat, rdv, errv);
        check("rd7_rdata", rdv, 32'h00AD_00EF);

        // Read held high across two addresses; addr changes mid-access
        d_read = 1'b1; d_addr = 10'd3;
        tick();
        d_addr = 10'd7;
        wait_rdy(0, lat);
        check("b2b_first_lat", 32'(lat + 1), 32'd5);
        check("b2b_first_rdata", d_rdata, 32'h1234_5678);
        wait_rdy(0, lat);
        check("b2b_spacing", 32'(lat), 32'd6);
        check("b2b_second_rdata", d_rdata, 32'h00AD_00EF);
        d_read = 1'b0;
        tick();

        // Read and write together: served as write, err flagged
        do_acc(0, 1, 1, 10'd2, 32'hCAFE_F00D, 4'hF, lat, rdv, errv);
        check("rw_lat", 32'(lat), 32'd5);
        check("rw_err", 32'(errv), 32'd1);
        check("rw_err_drop", 32'(d_err), 32'd0);
        do_acc(0, 1, 0, 10'd2, 32'h0, 4'h0, lat, rdv, errv);
        check("rd2_rdata", rdv, 32'hCAFE_F00D);
        check("rd2_err", 32'(errv), 32'd0);

        // Reset during BUSY of a write to word 9
        d_write = 1'b1; d_addr = 10'd9; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(d_ready), 32'd0);
        check("midrst_rdata", d_rdata, 32'd0);
        d_write = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (d_ready) seen++;
        end
        check("no_ready_when_idle", 32'(seen), 32'd0);
        do_acc(0, 1, 0, 10'd9, 32'h0, 4'h0, lat, rdv, errv);
        check("post_rst_lat", 32'(lat), 32'd5);
        check("post_rst_word9", rdv, 32'h1357_9BDF);

        // Stall injection: model LFSR (taps 16,14,13,11, left shift)
        lfsr_m = 16'hACE1;
        for (int i = 0; i < 100; i++) begin
            extra  = int'(lfsr_m[1:0]);
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            do_acc(1, 0, 1, 10'(i), 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203), 4'hF, lat, rdv, errv);
            check($sformatf("stall_wr_lat_%0d", i), 32'(lat), 32'(5 + extra));
        end
        for (int i = 0; i < 100; i++) begin
            extra  = int'(lfsr_m[1:0]);
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            do_acc(1, 1, 0, 10'(i), 32'h0, 4'h0, lat, rdv, errv);
            check($sformatf("stall_rd_lat_%0d", i), 32'(lat), 32'(5 + extra));
            check($sformatf("stall_rd_data_%0d", i), rdv, 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Variable-latency, word-addressed memory responder serving the core's `read`/`write`/`ready` request protocol from the responder side. Sits between the core's instruction or data port and a backing array. The bench preloads the array with `$readmemh` and dumps it with `$writememh` through the hierarchical path `mem_array`. It adds optional pseudo-random stall injection on top of fixed read and write latencies, so core stall logic is exercised under non-uniform timing.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width; must be a multiple of 8.
- `DEPTH`, 1024, number of words; must be a power of two.
- `READ_LATENCY`, 5, cycles from request to `ready` for a read; must be ≥1.
- `WRITE_LATENCY`, 5, cycles from request to `ready` for a write; must be ≥1.
- `STALL_SEED`, 16'h0000, LFSR seed. 0 disables stall injection; any other value enables it.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  $clog2(DEPTH)  word address.
- `wdata`  in  DATA_WIDTH  write data.
- `wstrb`  in  DATA_WIDTH/8  byte enables for writes.
- `write`  in  1  write request; held by the initiator until `ready`.
- `read`  in  1  read request; held by the initiator until `ready`.
- `rdata`  out  DATA_WIDTH  read data, valid in the `ready` cycle of a read and held until the next read completes.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  pulses together with `ready` when `read` and `write` were both high at acceptance.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: on `read|write`, capture `addr`, `wdata`, `wstrb` and the operation type. Load `cnt` = LAT−1+extra.
  - LAT is WRITE_LATENCY when `write`=1, otherwise READ_LATENCY.
  - extra = LFSR[1:0] when stalls are enabled, otherwise 0.
  - Next state is RESP if `cnt` would be 0, otherwise BUSY.
- BUSY: decrement `cnt`; when `cnt`==1, next state is RESP.
- Edge entering RESP, read: `rdata` <= `mem_array[addr_q]`.
- Edge entering RESP, write: for each byte i with `wstrb_q[i]`=1, write byte i of `wdata_q` into `mem_array[addr_q]`. Bytes with a 0 strobe are unchanged.
- RESP: `ready`=1 for exactly one cycle, then IDLE.
- Read and write both asserted: treated as a write; `err_q` is set and `err`=1 in the RESP cycle.
- Inputs that change after acceptance are ignored; the captured values are used.
- A request still high in the cycle after RESP is accepted as a new access. Back-to-back accesses therefore have one IDLE cycle between them.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per accepted request, and only when enabled.
- `mem_array` is never reset or cleared by the RTL.

## Timing
- Request first visible in cycle T (state IDLE) → `ready` in cycle T+LAT+extra.
- Sustained throughput: one access per LAT+extra+1 cycles.
- Read-after-write to the same address returns the new data, because the write commits at the edge entering RESP.
- Reset values: state=IDLE, `ready`=0, `err`=0, `rdata`=0, `cnt`=0, LFSR=STALL_SEED.
- Reset mid-access: the access is abandoned. A pending write is dropped and the array is unchanged. No `ready` is issued.
- Both strobes low in IDLE: no action and no `ready`.

## Structure
- Package `mem_if_pkg`:
  - `resp_state_e` enum (IDLE, BUSY, RESP).
  - `LFSR_TAPS` constant (16'hB400).
  - `STALL_BITS` = 2.
- Sub-module `lfsr16`: ports `clk`, `rst_n`, `en`, `seed`, `q[15:0]`. Instantiated only when `STALL_SEED`≠0, via a generate block.
- Array declared as `logic [DATA_WIDTH-1:0] mem_array [DEPTH]` at the top level of `dmem_responder`.

## Test plan
- Preload word 3 = 32'h1234_5678; read `addr`=3 held from cycle T, READ_LATENCY=5, stalls off → `ready`=1 only in T+5, `rdata`=32'h1234_5678, `err`=0.
- Write 32'hDEAD_BEEF to word 7 with `wstrb`=4'b0101 over 32'h0000_0000; then read word 7 → `rdata`=32'h00AD_00EF.
- Hold `read`=1 continuously across two addresses → `ready` pulses 6 cycles apart (LAT+1); each `rdata` matches its captured address even though `addr` changes mid-access.
- `read`=`write`=1, word 2 with `wstrb`=4'hF and `wdata`=32'hCAFE_F00D → one `ready` with `err`=1; a subsequent read of word 2 returns 32'hCAFE_F00D.
- Deassert `rst_n` during BUSY of a write to word 9 → `ready`=0 and `rdata`=0 immediately; word 9 keeps its preloaded value; the first request after reset is served normally.
- STALL_SEED=16'hACE1, 100 reads → every completion latency lies in 5–8 cycles; the latency sequence matches a reference model of the same LFSR; data is always correct.
